// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: the handshake and control bundle between the pipeline
// datapath and the hazard/stall sequencer.
//
// Signals, named from the sequencer's point of view:
//   dec_rn, dec_ab        REG/DEC read addresses (Rn and the Reg2Loc output)
//   dec_use_rn, dec_use_ab  REG/DEC instruction really reads that port
//   ex_rd, ex_load        destination and load flag of the EXEC instruction
//   dec_br_taken          branch resolved taken in REG/DEC
//   mem_req, mem_ready    ready/valid handshake with the data memory
//   pc_en, if_en          PC and IFETCH instruction register enables
//   if_flush              turn the fetched instruction into a NOP
//   id_bubble             zero the write/flag controls entering RegisterFetch
//   ex_en, wb_en          later pipeline register enables
//   mem_timeout           sticky memory wait timeout flag
//
// Modports: master = datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
  logic [4:0] dec_rn;
  logic [4:0] dec_ab;
  logic       dec_use_rn;
  logic       dec_use_ab;
  logic [4:0] ex_rd;
  logic       ex_load;
  logic       dec_br_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       if_en;
  logic       if_flush;
  logic       id_bubble;
  logic       ex_en;
  logic       wb_en;
  logic       mem_timeout;

  modport master (
    output dec_rn, dec_ab, dec_use_rn, dec_use_ab, ex_rd, ex_load,
           dec_br_taken, mem_req, mem_ready,
    input  pc_en, if_en, if_flush, id_bubble, ex_en, wb_en, mem_timeout
  );

  modport slave (
    input  dec_rn, dec_ab, dec_use_rn, dec_use_ab, ex_rd, ex_load,
           dec_br_taken, mem_req, mem_ready,
    output pc_en, if_en, if_flush, id_bubble, ex_en, wb_en, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall sequencer for the five-stage pipeline.
// Produces stage enables, the IFETCH flush and the REG/DEC bubble from
// load-use hazards, taken branches and the data memory handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   pif        pipeline_ctrl_if.slave (hazard inputs, memory handshake,
//              enables/flush/bubble outputs, sticky mem_timeout)
//   stall_cnt  saturating count of cycles with pc_en low
//   flush_cnt  saturating count of if_flush pulses
//
// Parameters: MAX_WAIT (memory wait cycles before timeout), CNT_W
// (performance counter width).
//
// Configuration: define PIPE_CTRL_PERF_EN to build the performance counters;
// without it stall_cnt and flush_cnt are tied to zero.
module pipeline_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   pif,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FLUSH} state_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_q;
  state_t            mode;
  logic              hazard;
  logic              mem_wait;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              pc_en_c;
  logic              if_en_c;
  logic              if_flush_c;
  logic              id_bubble_c;
  logic              ex_en_c;
  logic              wb_en_c;

  assign mem_wait = pif.mem_req & ~pif.mem_ready;

  // X31 is the zero register, so a load "to" it never creates a dependency.
  assign hazard = pif.ex_load && (pif.ex_rd != 5'd31) &&
                  ((pif.dec_use_rn && (pif.dec_rn == pif.ex_rd)) ||
                   (pif.dec_use_ab && (pif.dec_ab == pif.ex_rd)));

  // mode is the behaviour in force this cycle and is also the next state.
  // Stalls act in the cycle their condition appears; the registered state
  // only remembers what the previous cycle did. After a one-cycle stall or
  // flush the hazard and branch are not looked at again until RUN, which
  // guarantees the single bubble / single flushed slot.
  always_comb begin
    mode = RUN;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait)                 mode = MEM_WAIT;
        else if (hazard)              mode = LOAD_STALL;
        else if (pif.dec_br_taken)    mode = FLUSH;
        else                          mode = RUN;
      end
      LOAD_STALL, FLUSH: mode = mem_wait ? MEM_WAIT : RUN;
      default:           mode = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= mode;
  end

  // Reset overrides combinationally so the pipeline is frozen and bubbled
  // while rst is held, independent of the clock.
  always_comb begin
    pc_en_c     = 1'b1;
    if_en_c     = 1'b1;
    if_flush_c  = 1'b0;
    id_bubble_c = 1'b0;
    ex_en_c     = 1'b1;
    wb_en_c     = 1'b1;
    unique case (mode)
      MEM_WAIT: begin
        pc_en_c = 1'b0;
        if_en_c = 1'b0;
        ex_en_c = 1'b0;
        wb_en_c = 1'b0;
      end
      LOAD_STALL: begin
        pc_en_c     = 1'b0;
        if_en_c     = 1'b0;
        id_bubble_c = 1'b1;
      end
      FLUSH:   if_flush_c = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      pc_en_c     = 1'b0;
      if_en_c     = 1'b0;
      if_flush_c  = 1'b0;
      id_bubble_c = 1'b1;
      ex_en_c     = 1'b0;
      wb_en_c     = 1'b0;
    end
  end

  assign pif.pc_en       = pc_en_c;
  assign pif.if_en       = if_en_c;
  assign pif.if_flush    = if_flush_c;
  assign pif.id_bubble   = id_bubble_c;
  assign pif.ex_en       = ex_en_c;
  assign pif.wb_en       = wb_en_c;
  assign pif.mem_timeout = timeout_q;

  // wait_cnt holds the 0-based index of the current frozen cycle; the flag
  // sets at the end of the cycle whose index equals MAX_WAIT, i.e. once the
  // wait has lasted more than MAX_WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (mode == MEM_WAIT) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_MAX) timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en_c && (stall_q != '1))   stall_q <= stall_q + 1'b1;
      if (if_flush_c && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl. Control outputs
// are packed as {pc_en, if_en, if_flush, id_bubble, ex_en, wb_en}.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  localparam logic [31:0] RUN_O   = 32'b110011;
  localparam logic [31:0] STALL_O = 32'b000111;
  localparam logic [31:0] FLUSH_O = 32'b111011;
  localparam logic [31:0] WAIT_O  = 32'b000000;
  localparam logic [31:0] RESET_O = 32'b000100;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [5:0]       ctl;
  int               checks;
  int               errors;

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(
    .MAX_WAIT (15),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pif       (pif),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  assign ctl = {pif.pc_en, pif.if_en, pif.if_flush, pif.id_bubble, pif.ex_en, pif.wb_en};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rn, input logic [4:0] ab,
                               input logic use_rn, input logic use_ab,
                               input logic [4:0] rd, input logic load,
                               input logic br, input logic req, input logic ready);
    pif.dec_rn       = rn;
    pif.dec_ab       = ab;
    pif.dec_use_rn   = use_rn;
    pif.dec_use_ab   = use_ab;
    pif.ex_rd        = rd;
    pif.ex_load      = load;
    pif.dec_br_taken = br;
    pif.mem_req      = req;
    pif.mem_ready    = ready;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check the controls mid-cycle, then move to just after the next edge.
  task automatic cycleCheck(input string tag, input logic [31:0] expected);
    @(negedge clk);
    checkOutput(tag, {26'd0, ctl}, expected);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expCnt(input int n);
    int limit;
`ifdef PIPE_CTRL_PERF_EN
    limit = (1 << CNT_W) - 1;
`else
    limit = 0;
`endif
    return (n > limit) ? 32'(limit) : 32'(n);
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk    = 1'b0;
    rst    = 1'b0;
    checks = 0;
    errors = 0;
    idle();

    #2;
    checkOutput("reset_ctl", {26'd0, ctl}, RESET_O);
    checkOutput("reset_timeout", {31'd0, pif.mem_timeout}, 32'd0);
    checkOutput("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    cycleCheck("idle_run", RUN_O);

    // Load-use on Rn; hazard inputs held through the stall cycle's successor
    applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_rn_stall", STALL_O);
    cycleCheck("lu_rn_once", RUN_O);
    idle();
    checkOutput("lu_stall_cnt", {28'd0, stall_cnt}, expCnt(1));
    cycleCheck("lu_rn_after", RUN_O);

    // Load-use on the second read port
    applyStimulus(5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_ab_stall", STALL_O);
    idle();
    cycleCheck("lu_ab_release", RUN_O);

    // Matching address but port unused, and matching address without a load
    applyStimulus(5'd2, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycleCheck("ab_unused", RUN_O);
    applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cycleCheck("no_load", RUN_O);

    // Load to X31 never stalls
    applyStimulus(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    cycleCheck("x31_no_stall", RUN_O);

    // Taken branch: one flushed slot even if the branch input lingers
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycleCheck("br_flush", FLUSH_O);
    cycleCheck("br_once", RUN_O);
    idle();
    checkOutput("br_flush_cnt", {28'd0, flush_cnt}, expCnt(1));
    cycleCheck("br_after", RUN_O);

    // Four-cycle memory wait
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycleCheck("mw_freeze", WAIT_O);
    pif.mem_ready = 1'b1;
    cycleCheck("mw_resume", RUN_O);
    idle();
    checkOutput("mw_stall_cnt", {28'd0, stall_cnt}, expCnt(6));
    checkOutput("mw_no_timeout", {31'd0, pif.mem_timeout}, 32'd0);

    // Wait + hazard + branch together
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    cycleCheck("sim_wait", WAIT_O);
    cycleCheck("sim_wait", WAIT_O);
    pif.mem_ready = 1'b1;
    cycleCheck("sim_stall", STALL_O);
    idle();
    cycleCheck("sim_noflush", RUN_O);
    pif.dec_br_taken = 1'b1;
    cycleCheck("sim_rebranch", FLUSH_O);
    idle();
    cycleCheck("sim_after", RUN_O);
    checkOutput("sim_stall_cnt", {28'd0, stall_cnt}, expCnt(9));
    checkOutput("sim_flush_cnt", {28'd0, flush_cnt}, expCnt(2));

    // Sixteen wait cycles trip the timeout at MAX_WAIT=15
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("to_freeze", {26'd0, ctl}, WAIT_O);
      checkOutput("to_not_yet", {31'd0, pif.mem_timeout}, 32'd0);
      @(posedge clk);
      #1;
    end
    pif.mem_ready = 1'b1;
    checkOutput("to_set", {31'd0, pif.mem_timeout}, 32'd1);
    cycleCheck("to_resume", RUN_O);
    idle();
    cycleCheck("to_idle", RUN_O);
    cycleCheck("to_idle", RUN_O);
    checkOutput("to_sticky", {31'd0, pif.mem_timeout}, 32'd1);
    checkOutput("sat_stall_cnt", {28'd0, stall_cnt}, expCnt(25));

    // Asynchronous reset in the middle of a memory wait
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycleCheck("rst_pre_wait", WAIT_O);
    cycleCheck("rst_pre_wait", WAIT_O);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_ctl", {26'd0, ctl}, RESET_O);
    checkOutput("rst_async_timeout", {31'd0, pif.mem_timeout}, 32'd0);
    checkOutput("rst_async_stall", {28'd0, stall_cnt}, 32'd0);
    checkOutput("rst_async_flush", {28'd0, flush_cnt}, 32'd0);
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    cycleCheck("post_rst_run", RUN_O);
    pif.dec_br_taken = 1'b1;
    cycleCheck("post_rst_flush", FLUSH_O);
    idle();
    checkOutput("post_rst_flush_cnt", {28'd0, flush_cnt}, expCnt(1));
    checkOutput("post_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall sequencer for the five-stage ARM pipeline (IFETCH, REG/DEC, EXEC, MEM, WB). It produces per-stage enables, flush and bubble controls from three conditions:
- load-use hazards that forwarding cannot cover;
- taken branches resolved in REG/DEC;
- a ready/valid handshake to a multi-cycle data memory.

It sits beside the forwarding logic and drives the enable ports of the PC, the IFETCH instruction register, and the RegisterFetch and Execute pipeline registers.

## Interface
Parameters:
- MAX_WAIT, default 15: memory wait cycles allowed before a timeout is flagged.
- CNT_W, default 16: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- dec_rn  in  5  Rn field of the instruction in REG/DEC.
- dec_ab  in  5  second read address (Reg2Loc mux output) in REG/DEC.
- dec_use_rn  in  1  the REG/DEC instruction reads Rn.
- dec_use_ab  in  1  the REG/DEC instruction reads the second port.
- ex_rd  in  5  destination register of the instruction in EXEC.
- ex_load  in  1  the EXEC instruction is a load (mem_to_reg and reg_wr).
- dec_br_taken  in  1  branch resolved taken in REG/DEC.
- mem_req  in  1  the MEM-stage instruction accesses datamem.
- mem_ready  in  1  datamem has completed the current access.
- pc_en  out  1  PC may advance.
- if_en  out  1  IFETCH instruction register load enable.
- if_flush  out  1  replace the IFETCH instruction with a NOP at the next edge.
- id_bubble  out  1  zero the mem_wr, reg_wr and setFlags controls entering RegisterFetch.
- ex_en  out  1  RegisterFetch-to-Execute and Execute-to-MEM register enable.
- wb_en  out  1  MEM-to-WB register enable; when low, the register write is suppressed.
- mem_timeout  out  1  sticky; MEM_WAIT has exceeded MAX_WAIT cycles.
- stall_cnt  out  CNT_W  cycles in which pc_en was 0 (only with PIPE_CTRL_PERF_EN).
- flush_cnt  out  CNT_W  number of if_flush pulses (only with PIPE_CTRL_PERF_EN).

## Operation
The block is a four-state FSM: RUN, LOAD_STALL, MEM_WAIT, FLUSH.

- **Hazard term.** A hazard exists when ex_load is 1, ex_rd is not 31, and one of the following holds:
  - dec_use_rn is 1 and dec_rn equals ex_rd; or
  - dec_use_ab is 1 and dec_ab equals ex_rd.
- **Memory wait term.** A wait exists when mem_req is 1 and mem_ready is 0.
- **Priority** is evaluated every cycle: memory wait, then hazard, then branch.
- **RUN.** All enables are 1; if_flush and id_bubble are 0.
  - Wait → MEM_WAIT.
  - Otherwise hazard → LOAD_STALL.
  - Otherwise dec_br_taken → FLUSH.
- **MEM_WAIT.** pc_en, if_en, ex_en and wb_en are 0; id_bubble is 0, so the frozen state is preserved.
  - A 0-based wait counter increments each cycle.
  - mem_timeout is set when the counter reaches MAX_WAIT.
  - On mem_ready → RUN, and the counter clears.
- **LOAD_STALL.** Lasts exactly one cycle. pc_en and if_en are 0, id_bubble is 1, ex_en and wb_en are 1.
  - Wait pending → MEM_WAIT.
  - Otherwise → RUN.
  - The hazard is re-evaluated in RUN; with the load now in MEM, Dout forwarding clears it.
- **FLUSH.** Lasts one cycle. if_flush is 1 and all enables are 1, so the PC loads the branch target.
  - Then → RUN, or → MEM_WAIT if a wait is pending.
- **Suppressed branches.** dec_br_taken is ignored in any cycle where a hazard or wait is also present. The branch instruction stays in REG/DEC and is re-resolved later.
- **mem_timeout** clears only on reset.

## Timing
- The hazard and wait outputs are combinational from the current inputs and state, so a stall takes effect in the same cycle the condition appears. The state register updates on the edge.
- **Load-use penalty:** exactly 1 bubble. **Taken-branch penalty:** 1 flushed slot. **Memory wait:** N cycles of freeze for N cycles of mem_ready low.
- **Simultaneous events** (wait + hazard + branch in the same cycle): outputs follow MEM_WAIT. The hazard is re-detected after the wait and the branch is re-resolved after that.
- **Reset (rst low, asynchronous):**
  - State → RUN.
  - Wait counter, mem_timeout and both counters → 0.
  - Outputs while reset is held: pc_en=0, if_en=0, ex_en=0, wb_en=0, if_flush=0, id_bubble=1.
  - After reset deasserts, the block is in RUN from the first edge.
- **Reset mid-MEM_WAIT:** the block returns to RUN immediately; no partial state survives.
- **Counters:** stall_cnt and flush_cnt saturate at all-ones and never wrap.

## Configuration
- **PIPE_CTRL_PERF_EN defined:** stall_cnt and flush_cnt are implemented as described above.
- **PIPE_CTRL_PERF_EN undefined:** both outputs are tied to 0 and no counter flops are synthesized. FSM behaviour is identical in either build.

## Test plan
- **Load-use on Rn.** LDUR X3 with ex_load=1, ex_rd=3; dependent ADD with dec_rn=3, dec_use_rn=1 → one cycle of pc_en=0, if_en=0, id_bubble=1, then RUN; stall_cnt increments by 1.
- **No stall on X31.** ex_rd=31, dec_rn=31 with ex_load=1 → no stall; pc_en stays 1.
- **Taken branch.** dec_br_taken=1 in RUN → if_flush=1 for exactly one cycle; flush_cnt goes to 1.
- **Memory wait.** mem_req=1, mem_ready=0 for 4 cycles → pc_en, if_en, ex_en, wb_en all 0 for 4 cycles, then resume. Repeating with 16 cycles at MAX_WAIT=15 → mem_timeout=1 and it stays set.
- **Simultaneous events.** Wait, hazard and branch together → MEM_WAIT first, then a one-cycle LOAD_STALL if the hazard persists, and no flush until the branch is re-presented.
- **Async reset.** rst low mid-MEM_WAIT, between edges → outputs show reset values immediately; after release the FSM is in RUN and all counters read 0.
